// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and the elaboration-time KMP step used to
// build the per-state transition table of seq_detector_param.
package seq_det_pkg;

    localparam int MAX_PATTERN_W = 16;

    // Next state after accepting bit b in state k (0..width), where state k
    // means the last k accepted bits equal the top k bits of the pattern.
    // Returns the longest j such that the top j pattern bits are a suffix of
    // (top k pattern bits, b). Evaluated only on constant arguments.
    function automatic int next_state(
        input logic [MAX_PATTERN_W-1:0] pattern,
        input int                       width,
        input int                       k,
        input logic                     b
    );
        int   best;
        int   lim;
        int   idx;
        logic ok;
        logic sb;
        best = 0;
        lim  = (k + 1 < width) ? k + 1 : width;
        for (int j = 1; j <= MAX_PATTERN_W; j++) begin
            if (j <= lim) begin
                ok = 1'b1;
                for (int i = 0; i < MAX_PATTERN_W; i++) begin
                    if (i < j) begin
                        // Candidate string is indices 0..k: k prefix bits then b.
                        idx = k + 1 - j + i;
                        sb  = (idx < k) ? pattern[width-1-idx] : b;
                        if (pattern[width-1-i] != sb) ok = 1'b0;
                    end
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones.
// Ports: clk, rst (async high), clr (sync clear), inc (count enable),
//        count (current value).
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_count <= '0;
        else if (clr)                   r_count <= '0;
        else if (inc && r_count != '1)  r_count <= r_count + 1'b1;
    end

    assign count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: Moore detector for a PATTERN_W-bit serial pattern
// with run-time overlapping / non-overlapping mode and a saturating match
// counter.
// Ports: clk, rst (async high), clr (sync clear of state and count),
//        in_valid (qualifies x), x (serial bit, MSB of PATTERN first),
//        overlap (1: matches may overlap), y (high in MATCH),
//        match_cnt (saturating number of matches).
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                   PATTERN_W = 2,
    parameter logic [PATTERN_W-1:0] PATTERN   = 2'b10,
    parameter int                   CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             x,
    input  logic             overlap,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int             ST_W    = $clog2(PATTERN_W + 1);
    localparam logic [ST_W-1:0] S_MATCH = ST_W'(PATTERN_W);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_next;
    logic            w_inc;
    logic            w_bad;

    // Transition table, one entry per state for each input bit; fully
    // resolved at elaboration so there is no runtime prefix search.
    logic [PATTERN_W:0][ST_W-1:0] w_nxt0;
    logic [PATTERN_W:0][ST_W-1:0] w_nxt1;

    for (genvar k = 0; k <= PATTERN_W; k++) begin : g_tbl
        localparam int N0 = next_state(MAX_PATTERN_W'(PATTERN), PATTERN_W, k, 1'b0);
        localparam int N1 = next_state(MAX_PATTERN_W'(PATTERN), PATTERN_W, k, 1'b1);
        assign w_nxt0[k] = ST_W'(N0);
        assign w_nxt1[k] = ST_W'(N1);
    end

    assign w_bad = (r_state > S_MATCH);

    always_comb begin
        w_next = '0;
        if (r_state == S_MATCH && !overlap)
            // Non-overlapping: history restarts with the bit leaving MATCH.
            w_next = (x == PATTERN[PATTERN_W-1]) ? ST_W'(1) : '0;
        else if (!w_bad)
            w_next = x ? w_nxt1[r_state] : w_nxt0[r_state];
    end

    // Unreachable encodings recover to 0 on the next edge even when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_state <= '0;
        else if (clr)               r_state <= '0;
        else if (in_valid || w_bad) r_state <= in_valid ? w_next : '0;
    end

    assign w_inc = in_valid && (w_next == S_MATCH);

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (w_inc),
        .count (match_cnt)
    );

    assign y = (r_state == S_MATCH);

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three instances sharing the same stimulus
// (default "10" detector, 4-bit 1011 detector, 2-bit counter "11" detector)
// checked against a history-based reference model.
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst, clr, in_valid, x, overlap;
    logic       y0, y1, y2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    always #5 clk = ~clk;

    seq_detector_param d0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .x(x),
        .overlap(overlap), .y(y0), .match_cnt(c0));

    seq_detector_param #(.PATTERN_W(4), .PATTERN(4'b1011), .CNT_W(8)) d1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .x(x),
        .overlap(overlap), .y(y1), .match_cnt(c1));

    seq_detector_param #(.PATTERN_W(2), .PATTERN(2'b11), .CNT_W(2)) d2 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .x(x),
        .overlap(overlap), .y(y2), .match_cnt(c2));

    // Reference model: keep the accepted-bit history; a match is simply the
    // last PW bits equalling the pattern. Non-overlap clears history when
    // leaving a match.
    int          pw   [3] = '{2, 4, 2};
    logic [15:0] pat  [3] = '{16'b10, 16'b1011, 16'b11};
    int          cmax [3] = '{255, 255, 3};
    logic [15:0] h    [3];
    int          hl   [3];
    logic        my   [3];
    int          mc   [3];

    int n_cmp = 0;
    int n_err = 0;

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            h[i] = '0; hl[i] = 0; my[i] = 1'b0; mc[i] = 0;
        end
    endtask

    task automatic m_edge(input logic v, input logic b, input logic ov, input logic c);
        logic [15:0] mask;
        if (c) m_reset();
        else if (v) begin
            for (int i = 0; i < 3; i++) begin
                if (my[i] && !ov) begin h[i] = '0; hl[i] = 0; end
                h[i]  = {h[i][14:0], b};
                hl[i] = (hl[i] < 16) ? hl[i] + 1 : 16;
                mask  = (16'd1 << pw[i]) - 16'd1;
                my[i] = (hl[i] >= pw[i]) && ((h[i] & mask) == pat[i]);
                if (my[i] && mc[i] < cmax[i]) mc[i]++;
            end
        end
    endtask

    task automatic chk(input string tag);
        logic       dy [3];
        logic [7:0] dc [3];
        dy[0] = y0; dy[1] = y1; dy[2] = y2;
        dc[0] = c0; dc[1] = c1; dc[2] = {6'b0, c2};
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            assert (dy[i] === my[i]) else begin
                n_err++;
                $error("FAIL %s y[d%0d] got %b exp %b", tag, i, dy[i], my[i]);
            end
            n_cmp++;
            assert (dc[i] === 8'(mc[i])) else begin
                n_err++;
                $error("FAIL %s cnt[d%0d] got %0d exp %0d", tag, i, dc[i], mc[i]);
            end
        end
    endtask

    task automatic step(input logic v, input logic b, input logic ov, input logic c,
                        input string tag);
        in_valid = v; x = b; overlap = ov; clr = c;
        @(posedge clk);
        m_edge(v, b, ov, c);
        #1 chk(tag);
    endtask

    task automatic do_clr();
        step(1'b0, 1'b0, 1'b1, 1'b1, "clr");
    endtask

    task automatic stream(input logic [15:0] bits, input int n, input logic ov, input string tag);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], ov, 1'b0, tag);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; x = 1'b0; overlap = 1'b1;
        m_reset();
        #2 chk("reset");
        @(posedge clk); #1 rst = 1'b0;

        // 1011 stream 1,0,1,1,0,1,1 with overlap: d1 matches after bits 4 and 7.
        stream(16'b1011011, 7, 1'b1, "t2_ovl");
        n_cmp++;
        assert (c1 === 8'd2) else begin
            n_err++; $error("FAIL t2_cnt got %0d exp 2", c1);
        end

        // Asynchronous reset pulse strictly between edges.
        #2 rst = 1'b1;
        #1 m_reset(); chk("async_rst");
        #1 rst = 1'b0;

        // Same stream, non-overlapping: only one match.
        stream(16'b1011011, 7, 1'b0, "t3_novl");
        n_cmp++;
        assert (c1 === 8'd1) else begin
            n_err++; $error("FAIL t3_cnt got %0d exp 1", c1);
        end
        do_clr();

        // Partial-prefix fallback: 1,0,1,0,1,1 matches at bit 6 only.
        stream(16'b101011, 6, 1'b1, "t4_kmp");
        n_cmp++;
        assert (c1 === 8'd1 && y1 === 1'b1) else begin
            n_err++; $error("FAIL t4 got cnt %0d y %b exp cnt 1 y 1", c1, y1);
        end
        do_clr();

        // Default "10" with idle gaps; y holds while in_valid is low.
        step(1'b1, 1'b1, 1'b1, 1'b0, "t5_one");
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, "t5_gap");
        step(1'b1, 1'b0, 1'b1, 1'b0, "t5_zero");
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, "t5_hold");
        n_cmp++;
        assert (y0 === 1'b1) else begin
            n_err++; $error("FAIL t5_hold got %b exp 1", y0);
        end
        do_clr();

        // Eight 1s into "11" with a 2-bit counter: saturates at 3, clr clears.
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0, "t6_sat");
        n_cmp++;
        assert (c2 === 2'd3) else begin
            n_err++; $error("FAIL t6_sat got %0d exp 3", c2);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, "t6_clr");
        n_cmp++;
        assert (c2 === 2'd0 && y2 === 1'b0) else begin
            n_err++; $error("FAIL t6_clr got cnt %0d y %b exp 0 0", c2, y2);
        end

        // Random traffic: valid gaps, mode flips, occasional clears.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3) != 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(49) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
